// File: rtl/approx_div_pkg.sv
// Shared types and constants for the 8-by-4 restoring divider.
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DIVIDEND_W  = 8;
  localparam int DIVISOR_W   = 4;
  localparam int REM_W       = DIVISOR_W + 1;
  localparam int ITER_EXACT  = 8;
  localparam int ITER_APPROX = 6;

endpackage

// File: rtl/approx_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module approx_div_step
  import approx_div_pkg::*;
(
  input  logic [REM_W-1:0]     part_rem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [REM_W-1:0]     next_rem,
  output logic                 q_bit
);

  logic [REM_W:0] shifted;

  always_comb begin
    shifted  = {part_rem, next_bit};
    q_bit    = shifted >= (REM_W + 1)'(divisor);
    next_rem = q_bit ? REM_W'(shifted - (REM_W + 1)'(divisor)) : shifted[REM_W-1:0];
  end

endmodule

// File: rtl/approx_divider_8x4.sv
// Sequential 8/4 unsigned divider, one quotient bit per cycle, with
// divide-by-zero shortcut. Define APPROX_DIV_TRUNC_EN to stop after 6 bits.
module approx_divider_8x4
  import approx_div_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o
);

`ifdef APPROX_DIV_TRUNC_EN
  localparam int ITERS = ITER_APPROX;
  localparam bit TRUNC = 1'b1;
`else
  localparam int ITERS = ITER_EXACT;
  localparam bit TRUNC = 1'b0;
`endif

  state_t                state, state_next;
  logic [DIVIDEND_W-1:0] dividend_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [REM_W-1:0]      rem_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [2:0]            cnt_q;
  logic                  dbz_q;
  logic [REM_W-1:0]      step_rem;
  logic                  step_q;
  logic                  last_iter;
  logic                  zero_div;

  approx_div_step u_step (
    .part_rem (rem_q),
    .next_bit (dividend_q[DIVIDEND_W-1]),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  assign last_iter = (cnt_q == 3'(ITERS - 1));
  assign zero_div  = (divisor_q == '0);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_i) state_next = BUSY;
      BUSY:    if (zero_div || last_iter) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      dbz_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
          end
        end
        BUSY: begin
          if (zero_div) begin
            quo_q <= '1;
            rem_q <= {1'b0, dividend_q[DIVISOR_W-1:0]};
            dbz_q <= 1'b1;
          end else begin
            dividend_q <= dividend_q << 1;
            cnt_q      <= cnt_q + 3'd1;
            // Truncated build parks the 6 computed bits in [7:2] and drops the remainder.
            if (TRUNC && last_iter) begin
              quo_q <= {quo_q[4:0], step_q, 2'b00};
              rem_q <= '0;
            end else begin
              quo_q <= {quo_q[DIVIDEND_W-2:0], step_q};
              rem_q <= step_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o       = (state == IDLE);
  assign valid_o       = (state == DONE);
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q[DIVISOR_W-1:0];
  assign div_by_zero_o = dbz_q;

endmodule

// File: doc/approx_divider_8x4.md
APPROX_DIVIDER_8X4 -- requirements
Module: approx_divider_8x4

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port valid_i  input  1  dividend_i/divisor_i valid.
REQ-004 SHALL have port ready_o  output  1  block can accept an operand pair.
REQ-005 SHALL have port dividend_i  input  8  unsigned dividend (width of the 4x4 multiplier product).
REQ-006 SHALL have port divisor_i  input  4  unsigned divisor.
REQ-007 SHALL have port valid_o  output  1  result valid.
REQ-008 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-009 SHALL have port quotient_o  output  8  unsigned quotient.
REQ-010 SHALL have port remainder_o  output  4  unsigned remainder.
REQ-011 SHALL have port div_by_zero_o  output  1  result was produced by a zero divisor.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY, DONE; ready_o = (state==IDLE), valid_o = (state==DONE).
REQ-013 SHALL accept operands on an edge where valid_i && ready_o, latch them, clear the partial remainder and iteration counter, and go IDLE->BUSY.
REQ-014 SHALL ignore dividend_i/divisor_i/valid_i whenever ready_o is low.
REQ-015 SHALL, in BUSY, perform one restoring-division iteration per edge, MSB first: shift the partial remainder left, bring in the next dividend bit, subtract the divisor if the result is >= 0, and set that quotient bit.
REQ-016 SHALL hold the partial remainder at 5 bits so the compare/subtract never overflows.
REQ-017 SHALL, in exact mode, run 8 iterations; valid_o rises after the 8th edge following the accepting edge.
REQ-018 SHALL, for divisor 0, go BUSY->DONE on the first BUSY edge with quotient_o=8'hFF, remainder_o=dividend[3:0], div_by_zero_o=1.
REQ-019 SHALL hold quotient_o, remainder_o and div_by_zero_o stable while valid_o is high and ready_i is low.
REQ-020 SHALL go DONE->IDLE on an edge with ready_i high; no new operand is accepted on that same edge, so back-to-back throughput is one result per N+2 cycles.
REQ-021 SHALL clear div_by_zero_o on the next accept.

Reset
REQ-022 SHALL, on rst_i high at a rising edge, set state=IDLE, quotient_o=0, remainder_o=0, div_by_zero_o=0, valid_o=0, ready_o=1 (ready_o high from the first post-reset cycle).
REQ-023 SHALL abort any BUSY or DONE operation on reset and drop the result without emitting valid_o.
REQ-024 SHALL give rst_i priority over valid_i and ready_i on the same edge.

Configuration
REQ-025 SHALL honour the macro APPROX_DIV_TRUNC_EN.
- Defined: only 6 iterations run (quotient bits 7..2); quotient[1:0]=0; remainder_o=0; valid_o rises after the 6th edge after accept.
- The approximate quotient SHALL equal floor((dividend>>2)/divisor)<<2.
- Divide-by-zero behaviour is unchanged.
REQ-026 SHALL, with the macro undefined, produce exact quotient and remainder per REQ-017.

Structure
REQ-027 SHALL place the state enum, DIVIDEND_W=8, DIVISOR_W=4, and the ITER_EXACT=8 / ITER_APPROX=6 constants in package approx_div_pkg.
REQ-028 SHALL put one combinational iteration (shift/compare/subtract producing the next remainder and quotient bit) in sub-module approx_div_step, instantiated once.

Verification
REQ-029 SHALL cover exact mode: 200/7 -> quotient 28, remainder 4, valid_o after 8 edges.
REQ-030 SHALL cover exact mode: 255/1 -> quotient 255, remainder 0; 6/9 -> quotient 0, remainder 6.
REQ-031 SHALL cover divide-by-zero: 15/0 -> quotient 8'hFF, remainder 4'hF, div_by_zero_o=1, valid_o after 1 edge.
REQ-032 SHALL cover back-pressure: ready_i low for 3 cycles in DONE -> outputs and valid_o held; ready_o low throughout; valid_i pulses ignored.
REQ-033 SHALL cover reset mid-operation: rst_i at BUSY iteration 4 -> IDLE, valid_o never asserts, next op 50/5 -> quotient 10, remainder 0.
REQ-034 SHALL cover APPROX_DIV_TRUNC_EN defined: 103/3 -> quotient 32, remainder 0, valid_o after 6 edges (exact build gives 34 r1).
